// File: rtl/fan_pkg.sv
// Shared fan-control definitions: speed codes common with the speed controller,
// drive FSM states and a counter-width helper.
package fan_pkg;

  localparam logic [1:0] OFF    = 2'b00;
  localparam logic [1:0] LOW    = 2'b01;
  localparam logic [1:0] MEDIUM = 2'b10;
  localparam logic [1:0] HIGH   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KICK   = 2'd1,
    RAMP   = 2'd2,
    STEADY = 2'd3
  } fan_state_e;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    int w;
    if (n <= 1) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// Speed-code in / fan-drive out bundle between the speed controller (master)
// and the PWM driver (slave).
interface fan_pwm_driver_if #(
  parameter int PWM_BITS = 8
);
  logic [1:0]          speed;
  logic                tach;
  logic                pwm_out;
  logic [PWM_BITS-1:0] duty;
  logic                at_speed;
  logic                stall;

  modport master (output speed, output tach,
                  input  pwm_out, input duty, input at_speed, input stall);
  modport slave  (input  speed, input tach,
                  output pwm_out, output duty, output at_speed, output stall);
endinterface

// File: rtl/fan_pwm_timebase.sv
// Prescaler plus free-running PWM counter; period_end marks the last tick of
// each PWM period, where all duty and FSM updates happen.
module fan_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [PWM_BITS-1:0] o_cnt,
  output logic                o_tick,
  output logic                o_period_end
);

  localparam int PRE_W = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic                w_tick;

  assign w_tick       = (r_pre == PRE_W'(PRESCALE - 1));
  assign o_tick       = w_tick;
  assign o_cnt        = r_cnt;
  assign o_period_end = w_tick && (r_cnt == {PWM_BITS{1'b1}});

  // Prescaler wraps at PRESCALE-1; the PWM counter advances once per wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= {PRE_W{1'b0}};
      r_cnt <= {PWM_BITS{1'b0}};
    end else if (w_tick) begin
      r_pre <= {PRE_W{1'b0}};
      r_cnt <= r_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end else begin
      r_pre <= r_pre + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: speed code -> kick-start, linear duty ramp, steady drive.
// Build option FAN_STALL_DETECT_EN adds tach synchronisation and stall detection.
module fan_pwm_driver
  import fan_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 4,
  parameter int STEP         = 8,
  parameter int RAMP_PERIODS = 2,
  parameter int KICK_PERIODS = 16,
  parameter int DUTY_LOW     = 85,
  parameter int DUTY_MED     = 170,
  parameter int DUTY_HIGH    = 255
) (
  input logic            clk,
  input logic            reset_n,
  fan_pwm_driver_if.slave bus
);

  localparam logic [PWM_BITS-1:0] FULL   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ZERO   = {PWM_BITS{1'b0}};
  localparam int                  KICK_W = cnt_width(KICK_PERIODS);
  localparam int                  RAMP_W = cnt_width(RAMP_PERIODS);

  logic [PWM_BITS-1:0] w_cnt;
  logic                w_tick;
  logic                w_period_end;
  logic [PWM_BITS-1:0] w_target;
  logic [PWM_BITS-1:0] w_stepped;
  fan_state_e          w_settle_state;

  fan_state_e          r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_duty_cur, w_duty_cur_nxt;
  logic [KICK_W-1:0]   r_kick_cnt, w_kick_cnt_nxt;
  logic [RAMP_W-1:0]   r_ramp_cnt, w_ramp_cnt_nxt;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_pwm;
  logic                r_at_speed;

  // One saturating ramp step; the extra MSB keeps sums and differences exact.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS:0]   w_cur, w_tgt, w_stp, w_sum;
    logic [PWM_BITS-1:0] w_res;
    w_cur = {1'b0, cur};
    w_tgt = {1'b0, tgt};
    w_stp = (PWM_BITS + 1)'(STEP);
    w_res = cur;
    if (w_cur < w_tgt) begin
      w_sum = w_cur + w_stp;
      if (w_sum >= w_tgt) w_res = tgt;
      else                w_res = w_sum[PWM_BITS-1:0];
    end else if (w_cur > w_tgt) begin
      w_sum = w_tgt + w_stp;
      if (w_cur <= w_sum) begin
        w_res = tgt;
      end else begin
        w_sum = w_cur - w_stp;
        w_res = w_sum[PWM_BITS-1:0];
      end
    end else begin
      w_res = cur;
    end
    return w_res;
  endfunction

  fan_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .o_cnt        (w_cnt),
    .o_tick       (w_tick),
    .o_period_end (w_period_end)
  );

  // Speed code to target duty; sampled by the FSM only at period_end.
  always_comb begin
    w_target = ZERO;
    case (bus.speed)
      OFF:     w_target = ZERO;
      LOW:     w_target = PWM_BITS'(DUTY_LOW);
      MEDIUM:  w_target = PWM_BITS'(DUTY_MED);
      HIGH:    w_target = PWM_BITS'(DUTY_HIGH);
      default: w_target = ZERO;
    endcase
  end

  assign w_stepped      = step_toward(r_duty_cur, w_target);
  assign w_settle_state = (w_target == ZERO) ? IDLE : STEADY;

  // Drive sequencer; the kick exit doubles as the first ramp step so full
  // drive lasts exactly KICK_PERIODS periods.
  always_comb begin
    w_state_nxt    = r_state;
    w_duty_cur_nxt = r_duty_cur;
    w_kick_cnt_nxt = r_kick_cnt;
    w_ramp_cnt_nxt = r_ramp_cnt;
    if (w_period_end) begin
      case (r_state)
        IDLE: begin
          if (w_target != ZERO) begin
            w_state_nxt    = KICK;
            w_duty_cur_nxt = FULL;
            w_kick_cnt_nxt = {KICK_W{1'b0}};
          end else begin
            w_duty_cur_nxt = ZERO;
          end
        end
        KICK: begin
          if (r_kick_cnt == KICK_W'(KICK_PERIODS - 1)) begin
            w_duty_cur_nxt = w_stepped;
            w_kick_cnt_nxt = {KICK_W{1'b0}};
            w_ramp_cnt_nxt = {RAMP_W{1'b0}};
            w_state_nxt    = (w_stepped == w_target) ? w_settle_state : RAMP;
          end else begin
            w_kick_cnt_nxt = r_kick_cnt + KICK_W'(1);
          end
        end
        RAMP: begin
          if (r_duty_cur == w_target) begin
            w_state_nxt = w_settle_state;
          end else if (r_ramp_cnt == RAMP_W'(RAMP_PERIODS - 1)) begin
            w_duty_cur_nxt = w_stepped;
            w_ramp_cnt_nxt = {RAMP_W{1'b0}};
            w_state_nxt    = (w_stepped == w_target) ? w_settle_state : RAMP;
          end else begin
            w_ramp_cnt_nxt = r_ramp_cnt + RAMP_W'(1);
          end
        end
        STEADY: begin
          if (w_target != r_duty_cur) begin
            w_state_nxt    = RAMP;
            w_ramp_cnt_nxt = {RAMP_W{1'b0}};
          end else begin
            w_state_nxt = STEADY;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_duty_cur_nxt = ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Sequencer state and working counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_duty_cur <= ZERO;
      r_kick_cnt <= {KICK_W{1'b0}};
      r_ramp_cnt <= {RAMP_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_duty_cur <= w_duty_cur_nxt;
      r_kick_cnt <= w_kick_cnt_nxt;
      r_ramp_cnt <= w_ramp_cnt_nxt;
    end
  end

  // Applied duty changes only at the period wrap, so no runt pulses appear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty     <= ZERO;
      r_pwm      <= 1'b0;
      r_at_speed <= 1'b0;
    end else begin
      if (w_tick && w_period_end) begin
        r_duty <= w_duty_cur_nxt;
      end
      r_pwm      <= (r_duty == FULL) ? 1'b1 : (w_cnt < r_duty);
      r_at_speed <= (w_state_nxt == STEADY);
    end
  end

  assign bus.pwm_out  = r_pwm;
  assign bus.duty     = r_duty;
  assign bus.at_speed = r_at_speed;

`ifdef FAN_STALL_DETECT_EN
  logic       r_tach_meta, r_tach_sync, r_tach_prev;
  logic [1:0] r_edge_cnt;
  logic [5:0] r_win_cnt;
  logic       r_win_ok;
  logic       r_stall;
  logic       w_tach_rise;
  logic       w_win_end;

  assign w_tach_rise = r_tach_sync & ~r_tach_prev;
  assign w_win_end   = w_period_end && (r_win_cnt == 6'd63);

  // Two-flop synchroniser for the asynchronous tach input, plus edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tach_meta <= 1'b0;
      r_tach_sync <= 1'b0;
      r_tach_prev <= 1'b0;
    end else begin
      r_tach_meta <= bus.tach;
      r_tach_sync <= r_tach_meta;
      r_tach_prev <= r_tach_sync;
    end
  end

  // 64-period window: saturating edge count, at_speed must hold throughout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_cnt  <= 6'd0;
      r_edge_cnt <= 2'd0;
      r_win_ok   <= 1'b0;
    end else if (w_win_end) begin
      r_win_cnt  <= 6'd0;
      r_edge_cnt <= {1'b0, w_tach_rise};
      r_win_ok   <= r_at_speed;
    end else begin
      if (w_period_end) begin
        r_win_cnt <= r_win_cnt + 6'd1;
      end
      if (w_tach_rise && (r_edge_cnt != 2'd3)) begin
        r_edge_cnt <= r_edge_cnt + 2'd1;
      end
      r_win_ok <= r_win_ok & r_at_speed;
    end
  end

  // Sticky stall flag, released only once the sequencer is back in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall <= 1'b0;
    end else if (r_state == IDLE) begin
      r_stall <= 1'b0;
    end else if (w_win_end && r_win_ok && r_at_speed && (r_edge_cnt < 2'd2)) begin
      r_stall <= 1'b1;
    end
  end

  assign bus.stall = r_stall;
`else
  assign bus.stall = 1'b0;
`endif

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Bench for fan_pwm_driver: period-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed duty sequences.
module tb_fan_pwm_driver;
  import fan_pkg::*;

  localparam int PB     = 4;
  localparam int PERIOD = 16;
  localparam int FULLD  = 15;
  localparam int STEP_C = 4;
  localparam int RAMP_P = 1;
  localparam int KICK_P = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  fan_pwm_driver_if #(.PWM_BITS(PB)) bus ();

  fan_pwm_driver #(
    .PWM_BITS(PB), .PRESCALE(1), .STEP(STEP_C), .RAMP_PERIODS(RAMP_P),
    .KICK_PERIODS(KICK_P), .DUTY_LOW(5), .DUTY_MED(10), .DUTY_HIGH(15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: clocks since reset release, applied duty, sequence bookkeeping.
  int m_cyc = 0;
  int m_duty = 0;
  int m_kick_left = 0;
  int m_wait = 0;
  bit m_active = 1'b0;
  bit m_settled = 1'b0;
  bit m_exp_pwm = 1'b0;
  bit m_exp_at = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [1:0] s);
    case (s)
      OFF:     return 0;
      LOW:     return 5;
      MEDIUM:  return 10;
      HIGH:    return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int toward(input int d, input int t);
    if (d < t) return (d + STEP_C > t) ? t : d + STEP_C;
    if (d > t) return (d - STEP_C < t) ? t : d - STEP_C;
    return d;
  endfunction

  task automatic settle_if_done(input int t);
    if (m_duty == t) begin
      if (t == 0) begin
        m_active  = 1'b0;
        m_settled = 1'b0;
      end else begin
        m_settled = 1'b1;
      end
    end
  endtask

  task automatic model_boundary(input int t);
    if (m_kick_left > 0) begin
      m_kick_left--;
      if (m_kick_left == 0) begin
        m_duty = toward(m_duty, t);
        m_wait = RAMP_P;
        settle_if_done(t);
      end
    end else if (!m_active) begin
      if (t != 0) begin
        m_active    = 1'b1;
        m_settled   = 1'b0;
        m_kick_left = KICK_P;
        m_duty      = FULLD;
      end
    end else if (m_settled) begin
      if (t != m_duty) begin
        m_settled = 1'b0;
        m_wait    = RAMP_P;
      end
    end else if (m_duty == t) begin
      settle_if_done(t);
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_duty = toward(m_duty, t);
        m_wait = RAMP_P;
        settle_if_done(t);
      end
    end
    m_exp_at = m_active && m_settled;
  endtask

  // Model update: output is high for the first duty clocks of each period, one clock late.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cyc = 0; m_duty = 0; m_kick_left = 0; m_wait = 0;
        m_active = 1'b0; m_settled = 1'b0; m_exp_pwm = 1'b0; m_exp_at = 1'b0;
      end else begin
        m_cyc++;
        m_exp_pwm = (m_duty == FULLD) || (((m_cyc - 1) % PERIOD) < m_duty);
        if ((m_cyc % PERIOD) == 0) model_boundary(target_of(bus.speed));
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_pwm", int'(bus.pwm_out), 0);
        chk("rst_duty", int'(bus.duty), 0);
        chk("rst_at_speed", int'(bus.at_speed), 0);
      end else begin
        chk("pwm_out", int'(bus.pwm_out), int'(m_exp_pwm));
        chk("duty", int'(bus.duty), m_duty);
        chk("at_speed", int'(bus.at_speed), int'(m_exp_at));
`ifndef FAN_STALL_DETECT_EN
        chk("stall", int'(bus.stall), 0);
`endif
      end
    end
  end

  task automatic goto_phase(input int ph);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (((m_cyc % PERIOD) != ph) && (guard < 40));
    if ((m_cyc % PERIOD) != ph) chk("goto_phase", m_cyc % PERIOD, ph);
  endtask

  task automatic count_high(input int periods, output int hi);
    hi = 0;
    repeat (periods * PERIOD) begin
      @(negedge clk);
      hi += int'(bus.pwm_out);
    end
  endtask

  task automatic check_seq(input string name, input int n,
                           input int d0, input int d1, input int d2, input int d3, input int d4,
                           input int at_last);
    int dv[5];
    dv = '{d0, d1, d2, d3, d4};
    for (int i = 0; i < n; i++) begin
      repeat (PERIOD) @(negedge clk);
      chk({name, "_duty"}, int'(bus.duty), dv[i]);
      chk({name, "_at"}, int'(bus.at_speed), (i == n - 1) ? at_last : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    bus.speed = OFF;
    bus.tach  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(bus.pwm_out), 0);
    chk("reset_duty", int'(bus.duty), 0);
    chk("reset_at_speed", int'(bus.at_speed), 0);
    reset_n = 1'b1;

    // Standstill with OFF: nothing moves for 10 periods.
    count_high(10, hi);
    chk("t1_high_clks", hi, 0);
    chk("t1_duty", int'(bus.duty), 0);

    // OFF -> LOW: two kick periods, then 11, 7, 5.
    goto_phase(8);
    bus.speed = LOW;
    check_seq("t2", 5, 15, 15, 11, 7, 5, 1);
    count_high(1, hi);
    chk("t2_high_clks", hi, 5);

    // LOW -> HIGH: one settle period at 5, then 9, 13, 15.
    bus.speed = HIGH;
    check_seq("t3", 4, 5, 9, 13, 15, 0, 1);
    count_high(1, hi);
    chk("t3_high_clks", hi, 16);

    // HIGH -> OFF: ramp down to 0 and back to standstill.
    bus.speed = OFF;
    check_seq("t4", 5, 15, 11, 7, 3, 0, 0);
    count_high(1, hi);
    chk("t4_high_clks", hi, 0);
    chk("t4_at_speed", int'(bus.at_speed), 0);

    // LOW, MEDIUM, LOW inside one period: only the last value counts.
    goto_phase(2);
    bus.speed = LOW;
    goto_phase(6);
    bus.speed = MEDIUM;
    goto_phase(10);
    bus.speed = LOW;
    goto_phase(8);
    chk("t5_kick_duty", int'(bus.duty), 15);
    repeat (4 * PERIOD) @(negedge clk);
    chk("t5_final_duty", int'(bus.duty), 5);
    chk("t5_at_speed", int'(bus.at_speed), 1);

    // Mid-period change: applied duty holds until the wrap.
    goto_phase(3);
    bus.speed = MEDIUM;
    goto_phase(15);
    chk("t5_hold_duty", int'(bus.duty), 5);
    goto_phase(3);
    repeat (PERIOD) @(negedge clk);
    chk("t6_ramp_duty", int'(bus.duty), 9);
    chk("t6_pre_pwm", int'(bus.pwm_out), 1);

    // Asynchronous reset mid-ramp drops the drive within the cycle.
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_pwm_async", int'(bus.pwm_out), 0);
    chk("t6_duty_async", int'(bus.duty), 0);
    chk("t6_at_async", int'(bus.at_speed), 0);
    bus.speed = OFF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    count_high(3, hi);
    chk("t6_after_reset_high", hi, 0);
    chk("t6_after_reset_duty", int'(bus.duty), 0);

`ifdef FAN_STALL_DETECT_EN
    begin
      int n;
      bus.speed = LOW;
      n = 0;
      while (!bus.at_speed && n < 12 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      chk("t7_at_speed", int'(bus.at_speed), 1);
      n = 0;
      while (!bus.stall && n < 140 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      chk("t7_stall_set", int'(bus.stall), 1);
      bus.speed = OFF;
      n = 0;
      while (bus.stall && n < 10 * PERIOD) begin
        @(negedge clk);
        n++;
      end
      chk("t7_stall_clear", int'(bus.stall), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
